// File: rtl/huffman_decoder.sv
// Streaming prefix-code decoder for 4-bit symbols.
// One codeword is decoded from the head of a 10-bit look-ahead window per clock.
module huffman_decoder #(
   parameter int WIN_W = 10,
   parameter int SYM_W = 4,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIN_W-1:0] encodedData,
   input  logic             load,
   output logic             ready,
   output logic [SYM_W-1:0] decodedData,
   output logic [LEN_W-1:0] symbolLength
);

   typedef enum logic {FILL, DECODE} state_t;

   state_t           state;
   logic [5:0]       head;
   logic [SYM_W-1:0] sym;
   logic [LEN_W-1:0] len;
   logic             unused;

   assign head   = encodedData[WIN_W-1 -: 6];
   assign unused = ^encodedData[WIN_W-7:0];

   // Canonical codebook: 1 / 00xx / 010xx,01100 / 01101x,0111xx
   always_comb begin
      sym = '0;
      len = LEN_W'(1);
      priority casez (head)
         6'b1?????: begin
            sym = '0;
            len = LEN_W'(1);
         end
         6'b00????: begin
            sym = SYM_W'(head[3:2]) + SYM_W'(1);
            len = LEN_W'(4);
         end
         6'b010???: begin
            sym = SYM_W'(head[2:1]) + SYM_W'(5);
            len = LEN_W'(5);
         end
         6'b01100?: begin
            sym = SYM_W'(9);
            len = LEN_W'(5);
         end
         default: begin
            sym = SYM_W'(head[2:0]) + SYM_W'(8);
            len = LEN_W'(6);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= FILL;
         ready        <= 1'b1;
         decodedData  <= '0;
         symbolLength <= LEN_W'(WIN_W);
      end else begin
         case (state)
            FILL: begin
               if (load) begin
                  decodedData  <= sym;
                  symbolLength <= len;
                  state        <= DECODE;
               end
            end
            DECODE: begin
               if (load) begin
                  decodedData  <= sym;
                  symbolLength <= len;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed vectors, codebook sweep,
// and streams encoded from symbol lists driven by a negedge shifting producer.
module tb_huffman_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] encodedData;
   logic       load;
   logic       ready;
   logic [3:0] decodedData;
   logic [3:0] symbolLength;

   int checks = 0;
   int errors = 0;

   int code_v[16] = '{1, 0, 1, 2, 3, 8, 9, 10, 11, 12, 26, 27, 28, 29, 30, 31};
   int code_l[16] = '{1, 4, 4, 4, 4, 5, 5, 5, 5, 5, 6, 6, 6, 6, 6, 6};

   typedef struct {
      logic [9:0] win;
      int         sym;
      int         len;
   } vec_t;

   vec_t vt[7];
   int   exp_q[$];
   bit   bits_q[$];

   huffman_decoder dut (
      .clk(clk),
      .rst(rst),
      .encodedData(encodedData),
      .load(load),
      .ready(ready),
      .decodedData(decodedData),
      .symbolLength(symbolLength)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic bit pop_bit();
      if (bits_q.size() > 0) return bits_q.pop_front();
      return 1'($urandom_range(0, 1));
   endfunction

   // Encode a list of symbols into the bit queue, MSB of each code first
   task automatic build(input int n, input bit directed);
      int d[9] = '{1, 1, 0, 0, 0, 0, 15, 0, 3};
      exp_q.delete();
      bits_q.delete();
      for (int i = 0; i < n; i++) begin
         int s;
         s = directed ? d[i % 9] : int'($urandom_range(0, 15));
         exp_q.push_back(s);
         for (int b = code_l[s] - 1; b >= 0; b--)
            bits_q.push_back(1'((code_v[s] >> b) & 1));
      end
   endtask

   // Call just after a posedge sample point; asserts rst away from edges
   task automatic do_reset();
      #2;
      rst  = 1'b0;
      load = 1'b0;
      #1;
      chk("async_rst_ready", int'(ready), 1);
      chk("async_rst_len", int'(symbolLength), 10);
      chk("async_rst_data", int'(decodedData), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_stream(input int nsym, input int st_at,
                             input int st_len, input bit rnd);
      int k = 0;
      int cyc = 0;
      int pe_sym = 0;
      int pe_len = 10;
      while (k < nsym && cyc < 4000) begin
         bit stall;
         @(negedge clk);
         stall = (cyc >= st_at && cyc < st_at + st_len) ||
                 (rnd && $urandom_range(0, 4) == 0);
         if (stall) begin
            load = 1'b0;
         end else begin
            int         l;
            logic [9:0] w;
            l = int'(symbolLength);
            w = encodedData;
            for (int i = 0; i < l; i++) w = {w[8:0], pop_bit()};
            encodedData = w;
            load = 1'b1;
         end
         @(posedge clk);
         #1;
         chk("stream_ready", int'(ready), 1);
         if (load) begin
            pe_sym = exp_q[k];
            pe_len = code_l[exp_q[k]];
            chk($sformatf("stream_sym[%0d]", k), int'(decodedData), pe_sym);
            chk($sformatf("stream_len[%0d]", k), int'(symbolLength), pe_len);
            k++;
         end else begin
            chk("stall_hold_sym", int'(decodedData), pe_sym);
            chk("stall_hold_len", int'(symbolLength), pe_len);
         end
         cyc++;
      end
      if (k < nsym) chk("stream_timeout", k, nsym);
   endtask

   initial begin
      vt[0] = '{10'b1000000000, 0, 1};
      vt[1] = '{10'b0000101101, 1, 4};
      vt[2] = '{10'b0011010110, 4, 4};
      vt[3] = '{10'b0100011011, 5, 5};
      vt[4] = '{10'b0110011110, 9, 5};
      vt[5] = '{10'b0110101001, 10, 6};
      vt[6] = '{10'b0111110110, 15, 6};

      rst = 1'b0;
      load = 1'b0;
      encodedData = 10'($urandom);
      repeat (2) @(negedge clk);
      #2;
      chk("por_ready", int'(ready), 1);
      chk("por_len", int'(symbolLength), 10);
      chk("por_data", int'(decodedData), 0);
      @(negedge clk);
      rst = 1'b1;

      // Idle in FILL: window contents must be ignored without load
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         encodedData = 10'($urandom);
         @(posedge clk);
         #1;
         chk("idle_ready", int'(ready), 1);
         chk("idle_len", int'(symbolLength), 10);
         chk("idle_data", int'(decodedData), 0);
      end

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         encodedData = vt[i].win;
         load = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_sym", i), int'(decodedData), vt[i].sym);
         chk($sformatf("vec%0d_len", i), int'(symbolLength), vt[i].len);
      end

      for (int s = 0; s < 16; s++) begin
         int         l;
         logic [9:0] w;
         l = code_l[s];
         w = 10'(code_v[s] << (10 - l)) |
             (10'($urandom) & 10'((1 << (10 - l)) - 1));
         @(negedge clk);
         encodedData = w;
         load = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("sweep%0d_sym", s), int'(decodedData), s);
         chk($sformatf("sweep%0d_len", s), int'(symbolLength), l);
      end

      do_reset();
      build(18, 1'b1);
      run_stream(18, 5, 3, 1'b0);

      do_reset();
      build(40, 1'b0);
      run_stream(20, -10, 0, 1'b0);
      do_reset();

      build(200, 1'b0);
      run_stream(200, -10, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
